// File: rtl/hs_fifo_pkg.sv
// Purpose : shared constants and width helpers for the hs_fifo block.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   DEF_WIDTH / DEF_DEPTH - default word width and entry count
//   clog2_f()             - constant ceil(log2) used for address widths
//   ptr_w()               - pointer width (address bits plus one wrap bit)
package hs_fifo_pkg;

  localparam int DEF_WIDTH = 179;
  localparam int DEF_DEPTH = 4;

  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  // The extra MSB distinguishes full from empty when the address bits match.
  function automatic int ptr_w(input int depth);
    return clog2_f(depth) + 1;
  endfunction

endpackage

// File: rtl/hs_fifo_mem.sv
// Purpose : DEPTH x WIDTH storage with synchronous write and registered read.
// Latency : read data appears one clock after re is sampled.
// Backpressure: none; the caller only issues accepted reads/writes.
//
// Ports:
//   clk, rstn     - clock, async active-low reset (clears only the read register)
//   we/waddr/wdata - write port
//   re/raddr       - read port; rdata holds its value while re is low
//   rdata          - registered read data
module hs_fifo_mem
  import hs_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = clog2_f(DEF_DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  // Array is left unreset so it can map onto block RAM.
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Output register carries the reset so Q reads zero straight out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/hs_fifo.sv
// Purpose : single-clock synchronous FIFO with registered read data and Full/Empty flags.
// Latency : Q updates on the edge that accepts RdEn; a write is readable from the next cycle.
// Backpressure: WrEn while Full and RdEn while Empty are silently ignored.
//
// Ports:
//   clk, rstn  - clock, async active-low reset
//   Data, WrEn - write data and request
//   RdEn       - read request
//   Q          - registered read data (holds between accepted reads)
//   Empty/Full - occupancy flags, decoded from the registered pointers
//   Wnum       - occupancy 0..DEPTH, present only when HS_FIFO_COUNT_EN is defined
module hs_fifo
  import hs_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [WIDTH-1:0]        Data,
  input  logic                    WrEn,
  input  logic                    RdEn,
  output logic [WIDTH-1:0]        Q,
  output logic                    Empty,
  output logic                    Full
`ifdef HS_FIFO_COUNT_EN
  ,
  output logic [ptr_w(DEPTH)-1:0] Wnum
`endif
);

  localparam int AW = clog2_f(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        wr_acc;
  logic        rd_acc;

  // Flags come straight from registered pointers, so an async reset
  // forces Empty=1/Full=0 without waiting for a clock.
  assign Empty = (wptr_q == rptr_q);
  assign Full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

  // No bypass: a write into an empty FIFO is not readable in the same cycle.
  assign wr_acc = WrEn && !Full;
  assign rd_acc = RdEn && !Empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_acc) wptr_d = wptr_q + PTR_ONE;
    if (rd_acc) rptr_d = rptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  hs_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rstn  (rstn),
    .we    (wr_acc),
    .waddr (wptr_q[AW-1:0]),
    .wdata (Data),
    .re    (rd_acc),
    .raddr (rptr_q[AW-1:0]),
    .rdata (Q)
  );

`ifdef HS_FIFO_COUNT_EN
  // Modular difference is exact because occupancy never exceeds DEPTH.
  assign Wnum = wptr_q - rptr_q;
`endif

endmodule

// File: tb/tb_hs_fifo.sv
module tb_hs_fifo;

  logic         clk;
  logic         rstn;
  logic [178:0] Data;
  logic         WrEn;
  logic         RdEn;
  logic [178:0] Q;
  logic         Empty;
  logic         Full;
`ifdef HS_FIFO_COUNT_EN
  logic [2:0]   wnum;
`endif

  int checks;
  int failures;

  hs_fifo dut (
    .clk   (clk),
    .rstn  (rstn),
    .Data  (Data),
    .WrEn  (WrEn),
    .RdEn  (RdEn),
    .Q     (Q),
    .Empty (Empty),
    .Full  (Full)
`ifdef HS_FIFO_COUNT_EN
    ,
    .Wnum  (wnum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] d;
    logic [7:0] q;
    logic       e;
    logic       f;
    logic [2:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [178:0] wide(input logic [7:0] v);
    return {v, 163'h0, v};
  endfunction

  task automatic add(input logic wr, input logic rd, input logic [7:0] d,
                     input logic [7:0] q, input logic e, input logic f,
                     input logic [2:0] cnt);
    vec_t v;
    v.wr = wr; v.rd = rd; v.d = d; v.q = q; v.e = e; v.f = f; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [178:0] act, input logic [178:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int wcnt;
  int rexp;

  initial begin
    checks = 0;
    failures = 0;
    rstn = 1'b0;
    Data = '0;
    WrEn = 1'b0;
    RdEn = 1'b0;

    // wr rd data  Q    E     F     Wnum
    add(1, 0, 8'h01, 8'h00, 1'b0, 1'b0, 3'd1);
    add(1, 0, 8'h02, 8'h00, 1'b0, 1'b0, 3'd2);
    add(1, 0, 8'h03, 8'h00, 1'b0, 1'b0, 3'd3);
    add(1, 0, 8'h04, 8'h00, 1'b0, 1'b1, 3'd4);
    add(1, 0, 8'h05, 8'h00, 1'b0, 1'b1, 3'd4);  // dropped while full
    add(0, 1, 8'h00, 8'h01, 1'b0, 1'b0, 3'd3);
    add(0, 1, 8'h00, 8'h02, 1'b0, 1'b0, 3'd2);
    add(0, 1, 8'h00, 8'h03, 1'b0, 1'b0, 3'd1);
    add(0, 1, 8'h00, 8'h04, 1'b1, 1'b0, 3'd0);
    add(0, 1, 8'h00, 8'h04, 1'b1, 1'b0, 3'd0);  // read while empty: Q holds
    add(1, 0, 8'h2A, 8'h04, 1'b0, 1'b0, 3'd1);
    add(0, 1, 8'h00, 8'h2A, 1'b1, 1'b0, 3'd0);  // single-cycle read latency
    add(0, 0, 8'h00, 8'h2A, 1'b1, 1'b0, 3'd0);
    add(1, 1, 8'h07, 8'h2A, 1'b0, 1'b0, 3'd1);  // empty: write only
    add(1, 0, 8'h08, 8'h2A, 1'b0, 1'b0, 3'd2);
    add(1, 1, 8'h09, 8'h07, 1'b0, 1'b0, 3'd2);  // concurrent, count steady
    add(1, 0, 8'h0A, 8'h07, 1'b0, 1'b0, 3'd3);
    add(1, 0, 8'h0B, 8'h07, 1'b0, 1'b1, 3'd4);
    add(1, 1, 8'h0C, 8'h08, 1'b0, 1'b0, 3'd3);  // full: read only
    add(0, 1, 8'h00, 8'h09, 1'b0, 1'b0, 3'd2);
    add(0, 1, 8'h00, 8'h0A, 1'b0, 1'b0, 3'd1);
    add(0, 1, 8'h00, 8'h0B, 1'b1, 1'b0, 3'd0);

    // Reset held for 97 ns, deliberately not aligned with clk.
    #50;
    chk("rst_empty", {178'h0, Empty}, 179'd1);
    chk("rst_full",  {178'h0, Full},  179'd0);
    chk("rst_q",     Q,               179'd0);
`ifdef HS_FIFO_COUNT_EN
    chk("rst_wnum",  {176'h0, wnum},  179'd0);
`endif
    #47;
    rstn = 1'b1;
    step();

    foreach (tbl[i]) begin
      WrEn = tbl[i].wr;
      RdEn = tbl[i].rd;
      Data = wide(tbl[i].d);
      step();
      chk($sformatf("vec%0d_q", i),     Q,               wide(tbl[i].q));
      chk($sformatf("vec%0d_empty", i), {178'h0, Empty}, {178'h0, tbl[i].e});
      chk($sformatf("vec%0d_full", i),  {178'h0, Full},  {178'h0, tbl[i].f});
`ifdef HS_FIFO_COUNT_EN
      chk($sformatf("vec%0d_wnum", i),  {176'h0, wnum},  {176'h0, tbl[i].cnt});
`endif
    end

    // Mid-stream async reset with two words held and Q non-zero.
    WrEn = 1'b1; RdEn = 1'b0;
    Data = wide(8'h33);
    step();
    Data = wide(8'h44);
    step();
    WrEn = 1'b0;
    chk("pre_rst_q", Q, wide(8'h0B));
    #3;
    rstn = 1'b0;
    #1;
    chk("midrst_empty", {178'h0, Empty}, 179'd1);
    chk("midrst_full",  {178'h0, Full},  179'd0);
    chk("midrst_q",     Q,               179'd0);
`ifdef HS_FIFO_COUNT_EN
    chk("midrst_wnum",  {176'h0, wnum},  179'd0);
`endif
    #20;
    rstn = 1'b1;
    step();
    chk("post_rst_empty", {178'h0, Empty}, 179'd1);

    // Streaming for 50 cycles with flow control from the flags.
    wcnt = 1;
    rexp = 1;
    for (int c = 0; c < 50; c++) begin
      WrEn = !Full;
      RdEn = !Empty;
      Data = wide(8'(wcnt));
      step();
      if (WrEn) wcnt = wcnt + 1;
      if (RdEn) begin
        chk($sformatf("stream_q%0d", rexp), Q, wide(8'(rexp)));
        rexp = rexp + 1;
      end
      chk("stream_flags", {178'h0, Full && Empty}, 179'd0);
    end
    WrEn = 1'b0;
    RdEn = 1'b0;
    chk("stream_progress", {178'h0, rexp >= 40}, 179'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
